// File: rtl/dst_fifo_pkg.sv
// Shared widths for the destination-port output FIFO.
package dst_fifo_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ENTRY_W = DATA_W + 1;
  localparam int unsigned CNT_W   = 16;

endpackage : dst_fifo_pkg

// File: rtl/dst_fifo_ram.sv
// Register-array storage: synchronous write port, asynchronous (show-ahead) read port.
module dst_fifo_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 65
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : dst_fifo_ram

// File: rtl/dst_fifo.sv
// Output buffer behind the compressor's 64-bit destination port: show-ahead read
// stream, back-pressure flags, accepted-word counter and job-done detection.
module dst_fifo
  import dst_fifo_pkg::*;
#(
  parameter int unsigned AW        = 4,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               clear,
  input  logic [DATA_W-1:0]  m_dst,
  input  logic               m_dst_putn,
  input  logic               m_dst_last,
  input  logic               m_endn,
  output logic               m_dst_full,
  output logic               m_dst_almost_full,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_last,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               done_o,
  output logic               ovf_o
);

  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_MARGIN);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               end_seen_q, end_seen_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               full, empty;
  logic               wr_en, rd_en;
  logic [AW:0]        free_cnt;
  logic [ENTRY_W-1:0] head_entry;

  // Full/empty come from the occupancy count only; pointers wrap freely.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign free_cnt = DEPTH_C - count_q;

  assign wr_en = !m_dst_putn && !full;
  assign rd_en = !empty && rd_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    end_seen_d = end_seen_q;
    done_d     = done_q;
    ovf_d      = ovf_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_cnt_d = '0;
      end_seen_d = 1'b0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (word_cnt_q != '1) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (!m_dst_putn && full) begin
        ovf_d = 1'b1;
      end
      if (!m_endn) begin
        end_seen_d = 1'b1;
      end
      done_d = end_seen_q && empty && m_dst_putn;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      end_seen_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      end_seen_q <= end_seen_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  dst_fifo_ram #(
    .AW (AW),
    .W  (ENTRY_W)
  ) u_ram (
    .clk_i   (wb_clk_i),
    .we_i    (wr_en && !clear),
    .waddr_i (wr_ptr_q),
    .wdata_i ({m_dst_last, m_dst}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  assign rd_data           = head_entry[DATA_W-1:0];
  assign rd_last           = head_entry[ENTRY_W-1];
  assign rd_valid          = !empty;
  assign m_dst_full        = full;
  assign m_dst_almost_full = (free_cnt <= AF_C);
  assign word_cnt          = word_cnt_q;
  assign done_o            = done_q;
  assign ovf_o             = ovf_q;

endmodule : dst_fifo

// File: tb/tb_dst_fifo.sv
// Scoreboard bench for dst_fifo: a queue-based reference model predicts flags and read data.
module tb_dst_fifo;

  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [63:0] din = '0;
  logic        putn = 1'b1;
  logic        last = 1'b0;
  logic        endn = 1'b1;
  logic        ready = 1'b0;

  logic        full_o, afull_o, rd_last_o, rd_valid_o, done_w, ovf_w;
  logic [63:0] rd_data_o;
  logic [15:0] word_cnt_o;

  int errors = 0;
  int checks = 0;

  logic [64:0] expq [$];
  logic [64:0] head;
  int          mcnt;
  int          mwc;
  bit          movf, mend, mdone;

  dst_fifo #(.AW(4), .AF_MARGIN(AFM)) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .clear             (clr),
    .m_dst             (din),
    .m_dst_putn        (putn),
    .m_dst_last        (last),
    .m_endn            (endn),
    .m_dst_full        (full_o),
    .m_dst_almost_full (afull_o),
    .rd_data           (rd_data_o),
    .rd_last           (rd_last_o),
    .rd_valid          (rd_valid_o),
    .rd_ready          (ready),
    .word_cnt          (word_cnt_o),
    .done_o            (done_w),
    .ovf_o             (ovf_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcnt  = 0;
    mwc   = 0;
    movf  = 0;
    mend  = 0;
    mdone = 0;
    expq.delete();
  endtask

  task automatic check_flags();
    chk("rd_valid", 64'(rd_valid_o), 64'(mcnt != 0));
    chk("full", 64'(full_o), 64'(mcnt == DEPTH));
    chk("almost_full", 64'(afull_o), 64'((DEPTH - mcnt) <= AFM));
    chk("word_cnt", 64'(word_cnt_o), 64'(mwc));
    chk("done", 64'(done_w), 64'(mdone));
    chk("ovf", 64'(ovf_w), 64'(movf));
  endtask

  // One clock of stimulus; accepted words are pushed to the scoreboard as issued.
  task automatic cyc(input bit p, input bit l, input logic [63:0] d,
                     input bit r, input bit e, input bit c);
    bit w, rr;
    putn = p; last = l; din = d; ready = r; endn = e; clr = c;
    if (!c && !p && mcnt < DEPTH) expq.push_back({l, d});
    @(negedge clk);
    check_flags();
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      w  = !p && (mcnt < DEPTH);
      rr = (mcnt != 0) && r;
      if (!p && mcnt == DEPTH) movf = 1;
      if (w && mwc < 65535) mwc++;
      mdone = mend && (mcnt == 0) && p;
      if (!e) mend = 1;
      mcnt = mcnt + int'(w) - int'(rr);
    end
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1, 0, 64'h0, r, 1, 0);
  endtask

  // Monitor: every handshake pops and compares the oldest predicted word.
  always @(negedge clk) begin
    if (!rst && !clr && rd_valid_o === 1'b1 && ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got word %0h expected none", rd_data_o);
      end else begin
        head = expq.pop_front();
        chk("rd_data", rd_data_o, head[63:0]);
        chk("rd_last", 64'(rd_last_o), 64'(head[64]));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_flags();

    idle(10, 0);

    for (int i = 1; i <= 16; i++) cyc(0, i == 5, 64'(i), 0, 1, 0);
    cyc(0, 1, 64'hDEAD_BEEF, 0, 1, 0);
    idle(2, 0);
    idle(18, 1);

    for (int i = 0; i < 8; i++) cyc(0, 0, 64'h100 + 64'(i), 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, i[0], {32'h0, $urandom}, 1, 1, 0);
    idle(10, 1);

    for (int i = 0; i < 3; i++) cyc(0, i == 2, 64'hA0 + 64'(i), 0, 1, 0);
    cyc(1, 0, 64'h0, 0, 0, 0);
    idle(3, 0);
    idle(5, 1);
    cyc(0, 0, 64'hBEE, 0, 1, 0);
    idle(2, 0);
    cyc(1, 0, 64'h0, 0, 1, 1);
    idle(3, 0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
          {$urandom, $urandom}, 1'($urandom_range(0, 99) < 50),
          $urandom_range(0, 79) != 0, $urandom_range(0, 149) == 0);
    end
    idle(20, 1);

    cyc(1, 0, 64'h0, 0, 1, 1);
    for (int i = 0; i < 17; i++) cyc(0, 0, 64'h300 + 64'(i), 0, 1, 0);
    idle(11, 1);
    idle(1, 0);
    putn = 1'b0; din = 64'h5555; ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("async_rst_full", 64'(full_o), 64'd0);
    chk("async_rst_ovf", 64'(ovf_w), 64'd0);
    chk("async_rst_word_cnt", 64'(word_cnt_o), 64'd0);
    chk("async_rst_done", 64'(done_w), 64'd0);
    putn = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle(4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dst_fifo

// File: doc/dst_fifo.md
Name: dst_fifo

Overview:
- Output buffer directly downstream of the compression unit's 64-bit destination port.
- Accepts words strobed by m_dst_putn with a per-word last flag, and applies back-pressure through m_dst_full / m_dst_almost_full.
- Presents a show-ahead valid/ready read stream to the bus write-back master.
- Tracks the job-end strobe m_endn, counts accepted words and raises a done flag once the job has fully drained.

Parameters:
AW, 4, address width; FIFO depth = 2**AW entries.
AF_MARGIN, 4, m_dst_almost_full asserts when free entries <= AF_MARGIN; legal range 1..2**AW-1.

Ports:
wb_clk_i  input  1  clock.
wb_rst_i  input  1  reset, asynchronous, active-high.
clear  input  1  synchronous per-job clear of pointers, counters and flags.
m_dst  input  64  write data.
m_dst_putn  input  1  active-low write strobe, one word per low cycle.
m_dst_last  input  1  last-word flag, stored alongside the data.
m_endn  input  1  active-low job-end pulse.
m_dst_full  output  1  FIFO full.
m_dst_almost_full  output  1  free entries <= AF_MARGIN.
rd_data  output  64  head word.
rd_last  output  1  last flag of the head word.
rd_valid  output  1  head word valid (FIFO not empty).
rd_ready  input  1  consumer accepts the head word when rd_valid && rd_ready.
word_cnt  output  16  words accepted since reset/clear, saturating at 16'hFFFF.
done_o  output  1  job ended and FIFO drained.
ovf_o  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (async, wb_rst_i=1): wr_ptr=rd_ptr=0, count=0, word_cnt=0, end_seen=0, ovf_o=0. Outputs: m_dst_full=0, m_dst_almost_full=0, rd_valid=0, done_o=0. Storage array is not reset; rd_data/rd_last are don't-care while rd_valid=0.
- clear=1 has the same effect as reset at the next edge and overrides every other event in that cycle.
- Storage: 2**AW x 65 bits (data + last).
- Write: wr_en = !m_dst_putn && !full. Stores {m_dst_last, m_dst} at wr_ptr, increments wr_ptr modulo depth and increments word_cnt (saturating).
  - Write attempted while full: the word is dropped, ovf_o is set and stays set until reset/clear. The pointer and count are unchanged.
- Read: rd_en = rd_valid && rd_ready. rd_ptr increments modulo depth.
  - Show-ahead: rd_data/rd_last are combinational from mem[rd_ptr]. A word written in cycle N is visible in cycle N+1.
- Count update: +1 on wr_en only, -1 on rd_en only, unchanged when both occur.
  - Full is evaluated on the pre-edge count. A write together with a read while full is dropped and flags overflow. A write together with a read while empty is legal, and rd_valid stays 0 that cycle.
- Flags are derived from the registered count:
  - rd_valid = (count != 0).
  - m_dst_full = (count == 2**AW).
  - m_dst_almost_full = (2**AW - count <= AF_MARGIN).
  - Count is AW+1 bits wide.
- Wrap-around: pointers are AW bits and roll over naturally; full/empty come from count only, never from pointer compare.
- Job end: m_endn=0 sets end_seen, which is held until reset/clear.
  - done_o = end_seen && count==0 && m_dst_putn. It is registered, so it asserts one cycle after that condition holds and stays asserted while the condition holds.
  - If m_endn arrives while words are buffered, done_o waits for the drain.
  - A write after end_seen is still accepted and deasserts done_o.
- Mid-operation reset or clear discards all buffered words. rd_valid drops immediately on async reset, or at the next edge on clear.

Decomposition:
- Shared package or header: FIFO entry width constant (65) and the word_cnt width (16). No typedefs needed.
- One natural sub-module: dst_fifo_ram, the 2**AW x 65 register array with a synchronous write port and an asynchronous read port.
- Pointer, count, flag and done logic stay in dst_fifo.

Test Plan:
- Reset then idle: m_dst_putn=1, rd_ready=0 for 10 cycles -> rd_valid=0, m_dst_full=0, m_dst_almost_full=0, done_o=0, word_cnt=0.
- Fill AW=4, rd_ready=0, 16 writes of 64'h1..64'h10:
  - m_dst_almost_full rises after the 12th write.
  - m_dst_full rises after the 16th write.
  - A 17th write sets ovf_o=1, keeps word_cnt=16 and does not corrupt data.
- Drain with rd_ready=1 -> rd_data reads 1..16 in order with rd_last only on the word written with m_dst_last=1; rd_valid falls after the 16th read.
- Simultaneous read and write at count=8 for 20 cycles -> count stays 8, the flags are stable, and the data order is preserved across pointer wrap.
- m_endn pulse with 3 words buffered -> done_o=0 until the 3rd read, then 1 one cycle later. A subsequent write deasserts done_o. clear=1 returns all outputs to reset values.
- Assert async wb_rst_i mid-burst with count=5 -> rd_valid, m_dst_full, ovf_o and word_cnt are 0 immediately, before the next clock edge.
